// File: rtl/button_evt_pkg.sv
// Shared event encodings and helpers for the button event controller.
// Pending-flag vectors are indexed by event type code.
package button_evt_pkg;

   localparam int BTN_IDX_W = 3;

   typedef logic [1:0] evt_type_t;

   localparam evt_type_t EVT_PRESS   = 2'd0;
   localparam evt_type_t EVT_RELEASE = 2'd1;
   localparam evt_type_t EVT_LONG    = 2'd2;
   localparam evt_type_t EVT_REPEAT  = 2'd3;

   // PRESS ahead of RELEASE keeps a short tap in order even when both are pending.
   function automatic evt_type_t pick_type(input logic [3:0] pend);
      if (pend[EVT_PRESS])       return EVT_PRESS;
      else if (pend[EVT_LONG])   return EVT_LONG;
      else if (pend[EVT_REPEAT]) return EVT_REPEAT;
      else                       return EVT_RELEASE;
   endfunction

endpackage

// File: rtl/btn_rr_arbiter.sv
// Combinational round-robin arbiter: searches from last+1 upward, wrapping,
// and grants the first requesting button.
module btn_rr_arbiter
   import button_evt_pkg::*;
#(
   parameter int NUM_BTN = 4
) (
   input  logic [NUM_BTN-1:0]   req,
   input  logic [BTN_IDX_W-1:0] last,
   output logic [NUM_BTN-1:0]   gnt,
   output logic [BTN_IDX_W-1:0] gnt_idx
);

   int idx;

   // Walk from farthest to nearest so the nearest requester after last wins.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      idx     = 0;
      for (int i = NUM_BTN; i >= 1; i--) begin
         idx = (int'(last) + i) % NUM_BTN;
         if (req[idx]) begin
            gnt      = '0;
            gnt[idx] = 1'b1;
            gnt_idx  = BTN_IDX_W'(idx);
         end
      end
   end

endmodule

// File: rtl/button_event_ctrl.sv
// Turns debounced button levels into PRESS/RELEASE/LONG/REPEAT events and
// serialises them onto one valid/ready channel via a round-robin arbiter.
module button_event_ctrl
   import button_evt_pkg::*;
#(
   parameter int          NUM_BTN      = 4,
   parameter logic [15:0] TICK_DIV     = 16'd50000,
   parameter logic [7:0]  LONG_TICKS   = 8'd100,
   parameter logic [7:0]  REPEAT_TICKS = 8'd20
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic [NUM_BTN-1:0]   btn_i,
   output logic                 evt_valid,
   input  logic                 evt_ready,
   output logic [BTN_IDX_W-1:0] evt_btn,
   output evt_type_t            evt_type,
   output logic                 drop_o,
   input  logic                 drop_clr
);

   logic [15:0]          pre_cnt;
   logic                 tick;
   logic [NUM_BTN-1:0]   req;
   logic [NUM_BTN-1:0]   gnt;
   logic [NUM_BTN-1:0]   drop_hit;
   logic [BTN_IDX_W-1:0] gnt_idx;
   logic [BTN_IDX_W-1:0] rr_ptr;
   evt_type_t            btn_type [NUM_BTN];
   evt_type_t            sel_type;
   logic                 load;

   assign tick = (pre_cnt == TICK_DIV - 16'd1);
   assign load = !evt_valid || evt_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pre_cnt <= '0;
      else        pre_cnt <= tick ? '0 : pre_cnt + 16'd1;
   end

   for (genvar k = 0; k < NUM_BTN; k++) begin : g_btn
      logic       prev;
      logic       long_done;
      logic [7:0] hold_cnt;
      logic [7:0] rpt_cnt;
      logic [3:0] pend;
      logic [3:0] set_b;
      logic [3:0] cons_b;
      logic       rise;
      logic       fall;
      logic       held;

      assign rise = btn_i[k] & ~prev;
      assign fall = ~btn_i[k] & prev;
      assign held = btn_i[k] & prev;

      always_comb begin
         set_b = '0;
         if (en) begin
            if (rise) set_b[EVT_PRESS]   = 1'b1;
            if (fall) set_b[EVT_RELEASE] = 1'b1;
            if (held && tick) begin
               if (!long_done) begin
                  if (hold_cnt + 8'd1 == LONG_TICKS) set_b[EVT_LONG] = 1'b1;
               end else if (rpt_cnt + 8'd1 == REPEAT_TICKS) begin
                  set_b[EVT_REPEAT] = 1'b1;
               end
            end
         end
      end

      // A bit being set while it is also consumed survives, so it is not a drop.
      assign cons_b      = (load && gnt[k]) ? (4'b0001 << btn_type[k]) : 4'b0000;
      assign drop_hit[k] = |(set_b & pend & ~cons_b);
      assign req[k]      = |pend;
      assign btn_type[k] = pick_type(pend);

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            prev      <= 1'b0;
            long_done <= 1'b0;
            hold_cnt  <= '0;
            rpt_cnt   <= '0;
            pend      <= '0;
         end else begin
            prev <= btn_i[k];
            pend <= (pend & ~cons_b) | set_b;
            if (!en || rise || fall) begin
               hold_cnt  <= '0;
               rpt_cnt   <= '0;
               long_done <= 1'b0;
            end else if (held && tick) begin
               if (!long_done) begin
                  hold_cnt <= hold_cnt + 8'd1;
                  if (hold_cnt + 8'd1 == LONG_TICKS) long_done <= 1'b1;
               end else if (rpt_cnt + 8'd1 == REPEAT_TICKS) begin
                  rpt_cnt <= '0;
               end else begin
                  rpt_cnt <= rpt_cnt + 8'd1;
               end
            end
         end
      end
   end

   btn_rr_arbiter #(.NUM_BTN(NUM_BTN)) u_arb (
      .req     (req),
      .last    (rr_ptr),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   always_comb begin
      sel_type = EVT_PRESS;
      for (int k = 0; k < NUM_BTN; k++) begin
         if (gnt[k]) sel_type = btn_type[k];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         evt_valid <= 1'b0;
         evt_btn   <= '0;
         evt_type  <= EVT_PRESS;
         rr_ptr    <= BTN_IDX_W'(NUM_BTN - 1);
      end else if (load) begin
         if (|req) begin
            evt_valid <= 1'b1;
            evt_btn   <= gnt_idx;
            evt_type  <= sel_type;
            rr_ptr    <= gnt_idx;
         end else begin
            evt_valid <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)          drop_o <= 1'b0;
      else if (|drop_hit)  drop_o <= 1'b1;
      else if (drop_clr)   drop_o <= 1'b0;
   end

endmodule

// File: tb/tb_button_event_ctrl.sv
// Directed bench for button_event_ctrl: expected events are queued as stimulus
// is applied and compared against each accepted handshake.
module tb_button_event_ctrl;
   import button_evt_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic [3:0] btn_i;
   logic       evt_valid;
   logic       evt_ready;
   logic [2:0] evt_btn;
   evt_type_t  evt_type;
   logic       drop_o;
   logic       drop_clr;

   int         checks = 0;
   int         errors = 0;
   logic       got_evt;
   logic [4:0] sb [$];
   int         n;

   button_event_ctrl #(
      .NUM_BTN      (4),
      .TICK_DIV     (16'd4),
      .LONG_TICKS   (8'd3),
      .REPEAT_TICKS (8'd2)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .btn_i     (btn_i),
      .evt_valid (evt_valid),
      .evt_ready (evt_ready),
      .evt_btn   (evt_btn),
      .evt_type  (evt_type),
      .drop_o    (drop_o),
      .drop_clr  (drop_clr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input int b, input evt_type_t t);
      sb.push_back({3'(b), t});
   endtask

   // Samples at the falling edge; a valid&&ready seen here transfers at the next rising edge.
   task automatic cyc();
      logic [4:0] exp;
      @(negedge clk);
      got_evt = evt_valid && evt_ready;
      if (got_evt) begin
         chk("evt_expected", 32'(sb.size() > 0), 32'd1);
         if (sb.size() > 0) begin
            exp = sb.pop_front();
            chk("evt_btn_type", 32'({evt_btn, evt_type}), 32'(exp));
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int cycles);
      for (int i = 0; i < cycles; i++) cyc();
   endtask

   task automatic drain(input int budget, output int cnt);
      cnt = 0;
      while (sb.size() > 0 && cnt < budget) begin
         cyc();
         cnt++;
      end
      chk("drain_timeout", 32'(sb.size()), 32'd0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #20;
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b1; btn_i = '0; evt_ready = 1'b1; drop_clr = 1'b0;
      #3;
      chk("rst_valid", 32'(evt_valid), 32'd0);
      chk("rst_btn",   32'(evt_btn),   32'd0);
      chk("rst_type",  32'(evt_type),  32'd0);
      chk("rst_drop",  32'(drop_o),    32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      run(3);

      // Single press: valid exactly two edges after the input change, for one cycle.
      btn_i = 4'b0001; push(0, EVT_PRESS);
      cyc(); chk("t1_lat_a", 32'(got_evt), 32'd0);
      cyc(); chk("t1_lat_b", 32'(got_evt), 32'd0);
      cyc(); chk("t1_hit",   32'(got_evt), 32'd1);
      cyc(); chk("t1_single", 32'(got_evt), 32'd0);
      btn_i = 4'b0000; push(0, EVT_RELEASE);
      drain(10, n);

      // Long hold on button 2: PRESS, LONG after three ticks, REPEAT every 8 cycles.
      btn_i = 4'b0100; push(2, EVT_PRESS);
      drain(10, n); chk("t2_press_lat", 32'(n), 32'd3);
      push(2, EVT_LONG);
      drain(20, n); chk("t2_long_gap", 32'(n >= 9 && n <= 12), 32'd1);
      push(2, EVT_REPEAT);
      drain(20, n); chk("t2_rpt_gap1", 32'(n), 32'd8);
      push(2, EVT_REPEAT);
      drain(20, n); chk("t2_rpt_gap2", 32'(n), 32'd8);
      btn_i = 4'b0000; push(2, EVT_RELEASE);
      drain(10, n);
      run(24);

      // Simultaneous bursts from a fresh pointer: strict 0..3 order, back-to-back.
      do_reset();
      btn_i = 4'b1111;
      for (int b = 0; b < 4; b++) push(b, EVT_PRESS);
      drain(20, n); chk("t3_press_b2b", 32'(n), 32'd6);
      btn_i = 4'b0000;
      for (int b = 0; b < 4; b++) push(b, EVT_RELEASE);
      drain(20, n); chk("t3_rel_b2b", 32'(n), 32'd6);

      // Stall: output held stable; a repeated RELEASE while one is pending is lost.
      evt_ready = 1'b0;
      btn_i = 4'b0010; push(1, EVT_PRESS);
      run(3);
      btn_i = 4'b0000;
      run(2);
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("t4_stall_valid", 32'(evt_valid), 32'd1);
         chk("t4_stall_btn",   32'(evt_btn),   32'd1);
         chk("t4_stall_type",  32'(evt_type),  32'(EVT_PRESS));
      end
      chk("t4_no_drop_yet", 32'(drop_o), 32'd0);
      btn_i = 4'b0010; push(1, EVT_PRESS);
      run(2);
      // Both RELEASEs collapse into one pending flag.
      btn_i = 4'b0000; push(1, EVT_RELEASE);
      run(2);
      chk("t4_drop_set", 32'(drop_o), 32'd1);
      drop_clr = 1'b1;
      cyc();
      drop_clr = 1'b0;
      chk("t4_drop_clr", 32'(drop_o), 32'd0);
      evt_ready = 1'b1;
      drain(10, n);

      // Disabled: no events; enabling while held gives LONG only, timed from enable.
      en = 1'b0;
      btn_i = 4'b1000;
      run(80);
      en = 1'b1; push(3, EVT_LONG);
      drain(30, n); chk("t5_long_from_en", 32'(n >= 11 && n <= 14), 32'd1);
      btn_i = 4'b0000; push(3, EVT_RELEASE);
      drain(10, n);

      // Asynchronous reset during a stall discards everything.
      evt_ready = 1'b0;
      btn_i = 4'b0011;
      run(4);
      chk("t6_valid_before", 32'(evt_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("t6_async_valid", 32'(evt_valid), 32'd0);
      chk("t6_async_btn",   32'(evt_btn),   32'd0);
      chk("t6_async_type",  32'(evt_type),  32'd0);
      chk("t6_async_drop",  32'(drop_o),    32'd0);
      btn_i = 4'b0000;
      #15;
      rst_n = 1'b1;
      evt_ready = 1'b1;
      run(20);
      chk("t6_idle_valid", 32'(evt_valid), 32'd0);
      chk("sb_empty", 32'(sb.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
